hamming_tx_scheduler: RTL and testbench
=======================================

// Module: hamming_tx_scheduler
// PURPOSE
//  Shares one serial Hamming(7,4) TX line among N nibble requesters through a round-robin arbiter.
//  Encodes each granted nibble into a 7-bit codeword and frames it as start(0), 7 code bits LSB-first, stop(1).
//  The frame is sent one bit per clk, then followed by an idle gap.
//  Drives the RX input of the Hamming receiver; codeword bit order matches that receiver exactly.
// PARAMETERS
//  N_REQ       4   number of requesters (2..8)
//  GID_W       2   width of grant_id; must be >= clog2(N_REQ)
//  GAP_CYCLES  2   idle-high cycles after stop bit before next arbitration (>=1)
// PORTS
//  clk        in   1         rising-edge clock
//  rst        in   1         synchronous, active-high reset
//  req_valid  in   N_REQ     per-requester nibble valid
//  req_data   in   4*N_REQ   nibble i at [4i+3:4i]
//  req_ready  out  N_REQ     one-hot accept strobe; transfer when valid&ready at a clk edge
//  tx         out  1         serial line, idle high
//  busy       out  1         high from START through last GAP cycle
//  grant_id   out  GID_W     index of last granted requester
//  frame_cnt  out  16        frames completed (stop bit sent); wraps at 0xFFFF->0
//  inj_en     in   1         (ERR_INJECT_EN only) corrupt one code bit of next frame
//  inj_pos    in   3         (ERR_INJECT_EN only) code bit index 0..6 to flip
// BEHAVIOUR
//  Reset (rst=1 at edge): tx=1, busy=0, req_ready=0, grant_id=0, frame_cnt=0, rr pointer=0, state=IDLE.
//  Reset mid-frame aborts the frame: tx=1 from the next edge, no count, no partial resend.
//  FSM: IDLE -> START(1 cyc) -> DATA(7 cyc, bit idx 0..6) -> STOP(1 cyc) -> GAP(GAP_CYCLES) -> IDLE.
//  IDLE: tx=1, busy=0. If any req_valid, the winner is the first valid index at or after the pointer, wrapping.
//  req_ready[winner]=1 combinationally, only in IDLE. At that edge:
//    - nibble latched, grant_id<=winner, pointer<=(winner+1) mod N_REQ, state<=START.
//  No valid in IDLE: stay IDLE, pointer unchanged.
//  req_ready is 0 in every other state; valid held during a frame waits, nothing is dropped.
//  Encode, with d = latched nibble and codeword r[6:0]:
//    r2=d0, r4=d1, r5=d2, r6=d3, r0=d0^d1^d3, r1=d0^d2^d3, r3=d1^d2^d3
//  Codeword is registered at the grant edge. DATA cycle k drives tx=r[k].
//  START tx=0. STOP tx=1. frame_cnt increments on the STOP->GAP edge. GAP tx=1.
//  Latency: grant edge -> start bit on tx in the following cycle.
//  Minimum frame period = 1 IDLE + 9 + GAP_CYCLES cycles (12 at default).
//  Valid deasserted before the grant edge: no transfer, no state change.
//  Simultaneous valids: exactly one ready per IDLE cycle. A requester never waits more than N_REQ-1 frames.
// CONFIGURATION
//  ERR_INJECT_EN defined:
//    - inj_en/inj_pos ports exist. inj_en sampled at the grant edge flips r[inj_pos] of that frame only.
//    - inj_pos 7 means no flip.
//  ERR_INJECT_EN undefined:
//    - ports absent, codeword always clean.
// TESTING
//  1. rst, req_valid=0001, data0=4'b1011 -> ready0 1 cyc. Next cycles tx = 0,1,0,1,0,1,0,1,1; then GAP high; frame_cnt=1.
//  2. data=4'h0 -> tx bits 0,0000000,1. data=4'hF -> tx bits 0,1111111,1.
//  3. req_valid=1111 held -> grant_id sequence 0,1,2,3,0. Grants exactly 12 cycles apart; no cycle with two ready bits.
//  4. rst asserted on DATA bit 3 -> tx=1 next cycle, busy=0, frame_cnt unchanged. Next grant goes to requester 0.
//  5. Valid raised on req2 mid-frame of req0 -> req2 granted at first IDLE, data intact.
//  6. ERR_INJECT_EN, data=4'b1011, inj_pos=2 -> code bits 1,0,0,0,1,0,1. Receiver still outputs 4'b1011.

Source files
------------

// File: rtl/hamming_tx_scheduler.sv
// hamming_tx_scheduler
//   Round-robin arbiter that shares one serial Hamming(7,4) TX line among
//   N_REQ nibble requesters. A granted nibble is encoded and sent as a frame:
//   start(0), code bits r0..r6 (LSB first), stop(1), then GAP_CYCLES idle-high
//   cycles before the next arbitration.
// Ports
//   clk, rst    rising-edge clock, synchronous active-high reset
//   req_valid   per-requester nibble valid
//   req_data    nibble i at [4i+3:4i]
//   req_ready   one-hot accept strobe, combinational, only asserted in IDLE
//   tx          serial line, idle high (registered)
//   busy        high from START through the last GAP cycle (registered)
//   grant_id    index of last granted requester (registered)
//   frame_cnt   frames completed, wrapping 16-bit count (registered)
//   inj_en      ERR_INJECT_EN only: flip one code bit of the frame granted now
//   inj_pos     ERR_INJECT_EN only: code bit to flip, 7 = no flip
// Build option: define ERR_INJECT_EN to add the error-injection ports.
module hamming_tx_scheduler #(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned GID_W      = 2,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
`ifdef ERR_INJECT_EN
  input  logic               inj_en,
  input  logic [2:0]         inj_pos,
`endif
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [4*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]   req_ready,
  output logic               tx,
  output logic               busy,
  output logic [GID_W-1:0]   grant_id,
  output logic [15:0]        frame_cnt
);

  localparam int unsigned CNT_W = ($clog2(GAP_CYCLES) > 3) ? $clog2(GAP_CYCLES) : 3;
  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_GAP   = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [GID_W-1:0] ptr_q, ptr_d;
  logic [GID_W-1:0] grant_id_q, grant_id_d;
  logic [6:0]       code_q, code_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;

  logic             win_any;
  logic [GID_W-1:0] win_idx;
  logic [3:0]       win_nib;
  logic [6:0]       inj_mask;
  int unsigned      rr_j;

  // Codeword r[6:0]: data at r2,r4,r5,r6; parity at r0,r1,r3.
  function automatic logic [6:0] encode(input logic [3:0] d);
    encode = {d[3], d[2], d[1], d[1] ^ d[2] ^ d[3],
              d[0], d[0] ^ d[2] ^ d[3], d[0] ^ d[1] ^ d[3]};
  endfunction

  // Round-robin pick: first valid index at or after the pointer, wrapping.
  always_comb begin
    win_any = 1'b0;
    win_idx = '0;
    rr_j    = 0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      rr_j = 32'(ptr_q) + i;
      if (rr_j >= N_REQ) rr_j = rr_j - N_REQ;
      if (!win_any && req_valid[IDX_W'(rr_j)]) begin
        win_any = 1'b1;
        win_idx = GID_W'(rr_j);
      end
    end
  end

  assign win_nib = 4'(req_data >> (32'(win_idx) * 32'd4));

`ifdef ERR_INJECT_EN
  // Single-bit corruption of the frame being granted; position 7 disables it.
  always_comb begin
    inj_mask = '0;
    if (inj_en && (inj_pos != 3'd7)) inj_mask = 7'(1) << inj_pos;
  end
`else
  assign inj_mask = '0;
`endif

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      ptr_q       <= '0;
      grant_id_q  <= '0;
      code_q      <= '0;
      frame_cnt_q <= '0;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      grant_id_q  <= grant_id_d;
      code_q      <= code_d;
      frame_cnt_q <= frame_cnt_d;
      tx_q        <= tx_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state: frame sequencing, grant capture and frame counting.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ptr_d       = ptr_q;
    grant_id_d  = grant_id_q;
    code_d      = code_q;
    frame_cnt_d = frame_cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (win_any) begin
          state_d    = S_START;
          grant_id_d = win_idx;
          ptr_d      = (win_idx == GID_W'(N_REQ - 1)) ? '0 : win_idx + GID_W'(1);
          code_d     = encode(win_nib) ^ inj_mask;
        end
      end
      S_START: begin
        state_d = S_DATA;
        cnt_d   = '0;
      end
      S_DATA: begin
        if (cnt_q == CNT_W'(6)) state_d = S_STOP;
        else                    cnt_d   = cnt_q + CNT_W'(1);
      end
      S_STOP: begin
        state_d     = S_GAP;
        cnt_d       = '0;
        frame_cnt_d = frame_cnt_q + 16'd1;
      end
      S_GAP: begin
        if (cnt_q == CNT_W'(GAP_CYCLES - 1)) state_d = S_IDLE;
        else                                 cnt_d   = cnt_q + CNT_W'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs: accept strobe from current state; line/busy precomputed for next state.
  always_comb begin
    req_ready = '0;
    tx_d      = 1'b1;
    busy_d    = (state_d != S_IDLE);
    if ((state_q == S_IDLE) && win_any && !rst) req_ready = N_REQ'(1) << win_idx;
    unique case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = code_d[cnt_d[2:0]];
      default: tx_d = 1'b1;
    endcase
  end

  assign tx        = tx_q;
  assign busy      = busy_q;
  assign grant_id  = grant_id_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_hamming_tx_scheduler.sv
// Bench for hamming_tx_scheduler: a cycle-level reference model predicts
// arbitration and queues expected frames; a line monitor decodes tx and
// scores each received frame against the queue.
module tb_hamming_tx_scheduler;

  localparam int N_REQ = 4;
  localparam int GID_W = 2;
  localparam int GAP   = 2;

  typedef struct {
    int         gid;
    logic [6:0] code;
    int         start_cyc;
  } exp_frame_t;

  logic               clk = 1'b0;
  logic               rst;
  logic [N_REQ-1:0]   req_valid;
  logic [4*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   req_ready;
  logic               tx;
  logic               busy;
  logic [GID_W-1:0]   grant_id;
  logic [15:0]        frame_cnt;
`ifdef ERR_INJECT_EN
  logic               inj_en;
  logic [2:0]         inj_pos;
`endif

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  exp_frame_t exp_q[$];
  int m_left, m_ptr, m_gid, m_frames;
  int granted;
  bit hold_mode;

  hamming_tx_scheduler #(.N_REQ(N_REQ), .GID_W(GID_W), .GAP_CYCLES(GAP)) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef ERR_INJECT_EN
    .inj_en    (inj_en),
    .inj_pos   (inj_pos),
`endif
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .tx        (tx),
    .busy      (busy),
    .grant_id  (grant_id),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, want, cyc);
    end
  endfunction

  // Hamming(7,4) by bit position: positions 1..7 map to r0..r6, parity bits
  // sit at power-of-two positions and cover every position sharing that bit.
  function automatic logic [6:0] ref_code(input logic [3:0] d);
    logic [7:1] pos;
    logic       par;
    int         di;
    pos = '0;
    di  = 0;
    for (int p = 1; p <= 7; p++) begin
      if ((p & (p - 1)) != 0) begin
        pos[p] = d[di];
        di++;
      end
    end
    for (int k = 0; k < 3; k++) begin
      par = 1'b0;
      for (int p = 1; p <= 7; p++)
        if ((((p >> k) & 1) == 1) && ((p & (p - 1)) != 0)) par ^= pos[p];
      pos[1 << k] = par;
    end
    return pos;
  endfunction

  // One clock of the reference model, then post-edge stimulus bookkeeping.
  task automatic cycle();
    int         w;
    int         idx;
    logic [6:0] code;
    @(negedge clk);
    granted = -1;
    if (rst) begin
      chk("req_ready_in_reset", 32'(req_ready), 32'd0);
      m_left   = 0;
      m_ptr    = 0;
      m_gid    = 0;
      m_frames = 0;
      exp_q.delete();
    end else begin
      chk("busy", 32'(busy), 32'(m_left != 0));
      if (m_left == 0) chk("tx_idle_high", 32'(tx), 32'd1);
      chk("grant_id", 32'(grant_id), 32'(m_gid));
      chk("frame_cnt", 32'(frame_cnt), 32'(m_frames & 16'hFFFF));
      w = -1;
      if (m_left == 0) begin
        for (int i = 0; i < N_REQ; i++) begin
          idx = (m_ptr + i) % N_REQ;
          if (w < 0 && req_valid[idx]) w = idx;
        end
      end
      if (w >= 0) begin
        chk("req_ready_grant", 32'(req_ready), 32'(1 << w));
        code = ref_code(req_data[4*w +: 4]);
`ifdef ERR_INJECT_EN
        if (inj_en && inj_pos != 3'd7) code[inj_pos] = ~code[inj_pos];
`endif
        exp_q.push_back('{gid: w, code: code, start_cyc: cyc + 1});
        m_ptr   = (w + 1) % N_REQ;
        m_gid   = w;
        m_left  = 9 + GAP;
        granted = w;
      end else begin
        chk("req_ready_idle", 32'(req_ready), 32'd0);
        if (m_left == GAP + 1) m_frames++;
        if (m_left != 0) m_left--;
      end
    end
    @(posedge clk);
    #1;
    if (granted >= 0) begin
      if (hold_mode) req_data[4*granted +: 4] = 4'($urandom);
      else           req_valid[granted] = 1'b0;
    end
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic run_until_grant(input string name);
    bit got;
    got = 1'b0;
    for (int k = 0; k < 30 && !got; k++) begin
      cycle();
      if (granted >= 0) got = 1'b1;
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL %s: no grant predicted within 30 cycles (cycle %0d)", name, cyc);
    end
  endtask

  // Line monitor: decode start + 7 code bits + stop, score against the queue.
  initial begin : mon
    bit         coll;
    int         n;
    int         scyc;
    logic [6:0] bits;
    exp_frame_t e;
    coll = 1'b0;
    n    = 0;
    scyc = 0;
    bits = '0;
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        coll = 1'b0;
      end else if (!coll) begin
        if (tx === 1'b0) begin
          coll = 1'b1;
          n    = 0;
          scyc = cyc;
        end
      end else if (n < 7) begin
        bits[n] = tx;
        n++;
      end else begin
        chk("stop_bit", 32'(tx), 32'd1);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_frame: code 0x%0h seen with no grant queued (cycle %0d)", bits, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("codeword", 32'(bits), 32'(e.code));
          chk("start_latency", 32'(scyc), 32'(e.start_cyc));
          chk("frame_grant_id", 32'(grant_id), 32'(e.gid));
        end
        coll = 1'b0;
      end
    end
  end

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    hold_mode = 1'b0;
    granted   = -1;
`ifdef ERR_INJECT_EN
    inj_en  = 1'b0;
    inj_pos = 3'd7;
`endif
    run(2);
    rst = 1'b0;
    run(2);

    // Single nibble 1011 on requester 0.
    req_data[3:0] = 4'b1011;
    req_valid     = 4'b0001;
    run(15);

    // All-zero and all-one nibbles back to back.
    req_data[7:4]   = 4'h0;
    req_data[15:12] = 4'hF;
    req_valid       = 4'b1010;
    run(28);

    // Reset during DATA bit 3 of requester 2's frame.
    req_data[11:8] = 4'($urandom);
    req_valid      = 4'b0100;
    run_until_grant("grant_req2");
    run(4);
    rst = 1'b1;
    run(1);
    rst = 1'b0;

    // All requesters held valid: strict rotation starting from 0.
    hold_mode = 1'b1;
    req_valid = 4'b1111;
    run(62);
    hold_mode = 1'b0;
    req_valid = '0;
    run(14);

    // Requester 2 raises valid in the middle of requester 0's frame.
    req_data[3:0] = 4'($urandom);
    req_valid     = 4'b0001;
    run(5);
    req_data[11:8] = 4'($urandom);
    req_valid[2]   = 1'b1;
    run(30);

`ifdef ERR_INJECT_EN
    // Nibble 1011 with code bit 2 flipped.
    req_data[3:0] = 4'b1011;
    req_valid     = 4'b0001;
    inj_en        = 1'b1;
    inj_pos       = 3'd2;
    run_until_grant("grant_inject");
    inj_en = 1'b0;
    run(14);
`endif

    // Random traffic, including occasional withdrawals before grant.
    for (int c = 0; c < 700; c++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
          req_data[4*i +: 4] = 4'($urandom);
          req_valid[i]       = 1'b1;
        end else if (req_valid[i] && $urandom_range(0, 40) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
`ifdef ERR_INJECT_EN
      inj_en  = ($urandom_range(0, 3) == 0);
      inj_pos = 3'($urandom_range(0, 7));
`endif
      cycle();
    end

    req_valid = '0;
`ifdef ERR_INJECT_EN
    inj_en = 1'b0;
`endif
    run(20);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
